// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, source indices and arbitration defaults for the register-file
// writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned NSRC       = 3;
    localparam int unsigned STARVE_MAX = 4;

    localparam int unsigned SRC_LSU = 0;
    localparam int unsigned SRC_MDU = 1;
    localparam int unsigned SRC_ALU = 2;

endpackage

// File: rtl/regfile_wb_arbiter_wb_prio_arbiter.sv
// Fixed-priority one-hot arbiter with per-source starvation counters that
// promote a long-waiting source above the fixed order.
module wb_prio_arbiter #(
    parameter int unsigned NSRC       = regfile_wb_arbiter_pkg::NSRC,
    parameter int unsigned STARVE_MAX = regfile_wb_arbiter_pkg::STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] valid_i,
    input  logic            stall_i,
    output logic [NSRC-1:0] grant_o
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0]   cnt_q [NSRC];
    logic [CW-1:0]   cnt_d [NSRC];
    logic [NSRC-1:0] starved;

    always_comb begin
        grant_o = '0;
        starved = '0;
        for (int i = 0; i < NSRC; i++) begin
            starved[i] = valid_i[i] && (cnt_q[i] == CW'(STARVE_MAX));
        end
        // x & -x isolates the lowest set bit.
        if (!stall_i) begin
            if (|starved) grant_o = starved & (~starved + NSRC'(1));
            else          grant_o = valid_i & (~valid_i + NSRC'(1));
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!valid_i[i] || grant_o[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CW'(STARVE_MAX)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Serialises writeback results from several producers onto the single register
// file write port through a registered output stage.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN       = regfile_wb_arbiter_pkg::XLEN,
    parameter int unsigned NSRC       = regfile_wb_arbiter_pkg::NSRC,
    parameter int unsigned STARVE_MAX = regfile_wb_arbiter_pkg::STARVE_MAX
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NSRC-1:0]                           s_valid,
    output logic [NSRC-1:0]                           s_ready,
    input  logic [NSRC*regfile_wb_arbiter_pkg::REG_AW-1:0] s_rd,
    input  logic [NSRC*XLEN-1:0]                      s_data,
    input  logic                                      wb_stall,
    output logic                                      wen,
    output logic [regfile_wb_arbiter_pkg::REG_AW-1:0] waddr,
    output logic [XLEN-1:0]                           wdata,
    output logic [31:0]                               pending_mask,
    output logic [63:0]                               wb_count
);
    import regfile_wb_arbiter_pkg::*;

    logic [NSRC-1:0]   grant;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              xfer;
    logic              wr;

    logic              wen_q;
    logic [REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [63:0]       wb_count_q;

    wb_prio_arbiter #(
        .NSRC       (NSRC),
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s_valid),
        .stall_i (wb_stall),
        .grant_o (grant)
    );

    assign s_ready = grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                sel_rd   = s_rd[i*REG_AW +: REG_AW];
                sel_data = s_data[i*XLEN +: XLEN];
            end
        end
    end

    assign xfer = |(s_valid & grant);
    // Writes to x0 complete the handshake but never reach the port.
    assign wr   = xfer && (sel_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wb_count_q <= '0;
        end else begin
            wen_q <= wr;
            if (wr) begin
                waddr_q    <= sel_rd;
                wdata_q    <= sel_data;
                wb_count_q <= wb_count_q + 64'd1;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (s_valid[i]) pending_mask[s_rd[i*REG_AW +: REG_AW]] = 1'b1;
        end
        if (wen_q) pending_mask[waddr_q] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    assign wen      = wen_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign wb_count = wb_count_q;

endmodule
